i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

I2C target (responder) with a small byte-addressed register file. It sits directly downstream of the Wishbone-controlled I2C master on the shared open-drain SCL/SDA bus. It consumes the master's START/address/data/STOP sequences, ACKs its own address, and supports pointer-based register writes and auto-incrementing reads. The block is synthesizable and doubles as the reference responder in the master's bench.

## Interface
Parameters:
- TGT_ADDR, 7'h50, 7-bit target address matched against the first byte after START/repeated START
- NREGS, 16, register count (power of two, 2..256); pointer width PW = $clog2(NREGS)

Ports:
- clk  input  1  system clock; all state is sampled on its rising edge
- rst  input  1  asynchronous, active-high reset
- scl_i  input  1  resolved (wired-AND) SCL line
- sda_i  input  1  resolved (wired-AND) SDA line
- sda_o  output  1  SDA drive: 0 pulls low, 1 releases; bus resolves as the AND of all drivers
- scl_o  output  1  constant 1 (no clock stretching)
- busy  output  1  high from address match until STOP, repeated START or mismatch
- wr_stb  output  1  one-cycle pulse per register write accepted from the bus
- wr_addr  output  PW  register index written, valid with wr_stb
- wr_data  output  8  byte written, valid with wr_stb
- rd_idx  input  PW  local read index
- rd_data  output  8  reg[rd_idx], registered, 1-cycle latency

## Operation
- Line conditioning: scl_i and sda_i pass through a 2-flop synchronizer, then a rise/fall detector.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
- Data is sampled on SCL rise. sda_o changes only on SCL fall.
- States:
  - IDLE
  - ADDR: 8 bits
  - ADDR_ACK
  - PTR: 8 bits
  - PTR_ACK
  - WDATA
  - WDATA_ACK
  - RDATA
  - RDATA_ACK
  - IGNORE
- START from any state (including repeated START) goes to ADDR with the bit counter cleared. The pointer is kept.
- STOP from any state goes to IDLE with sda_o=1.
- ADDR complete:
  - Address matches, R/W=0: go to ADDR_ACK, then PTR.
  - Address matches, R/W=1: go to ADDR_ACK, then RDATA.
  - Mismatch: go to IGNORE with no ACK.
- PTR byte: ptr ← byte[PW-1:0], upper bits discarded; always ACKed; then WDATA.
- WDATA byte: reg[ptr] ← byte; wr_stb pulses; ACK; ptr ← ptr+1 (wraps NREGS-1→0).
- RDATA:
  - The shift register loads reg[ptr] on the SCL fall that ends ADDR_ACK or RDATA_ACK.
  - MSB first; sda_o = current bit.
  - After 8 bits, sda_o is released, ptr increments with wrap, and the master's ACK bit is sampled.
  - ACK (0) continues with the next byte. NACK (1) goes to IGNORE.
- ACK drive: sda_o=0 from the SCL fall after the 8th data rise until the next SCL fall.
- IGNORE: sda_o=1; wait for START or STOP.
- Local port: rd_data ← reg[rd_idx] every cycle. When a bus write targets the same index in the same cycle, rd_data shows the old value and updates one cycle later.
- Reset values:
  - sda_o=1, scl_o=1, busy=0, wr_stb=0, wr_addr=0, wr_data=0, rd_data=0
  - all registers 0, ptr=0, state IDLE
- Reset mid-transfer: on release, the block sits in IDLE and ignores the rest of the frame until a new START.

## Timing
- Condition-to-action latency: 3 clk (2 sync + 1 edge detect); 5 clk with the filter.
- SCL high and low phases must each be ≥4 clk (≥6 with the filter). SDA setup to SCL rise must be ≥3 clk.
- The wr_stb pulse occurs 1 clk after the SCL rise of the 8th WDATA bit is detected.
- START and STOP take priority over a coincident SCL edge in the same cycle.

## Configuration
- I2C_TGT_GLITCH_FILTER_EN:
  - Defined: a 3-sample majority filter follows each synchronizer. Pulses of 1 clk or less are rejected. Latency grows by 2 clk.
  - Undefined: synchronizer only. Any 1-clk glitch is seen as an edge.

## Structure
- Package i2c_tgt_pkg holds:
  - the state enum type
  - localparams I2C_ACK=1'b0 and I2C_NACK=1'b1
  - bit-count width
- Sub-module i2c_tgt_line_sync (synchronizer, optional filter, rise/fall pulses) is instantiated once for SCL and once for SDA.

## Test plan
- Write frame: START, 0xA0, 0x02, 0xA5, 0x3C, STOP → ACK on all 4 bytes; wr_stb at (2,A5) then (3,3C); rd_idx=3 gives rd_data=0x3C.
- Read with repeated START: START, 0xA0, 0x02, Sr, 0xA1, read 2 bytes (ACK then NACK), STOP → 0xA5 then 0x3C on SDA; busy falls at STOP.
- Address mismatch: START, 0xA2, 0x00, 0xFF, STOP → SDA never driven low; no wr_stb; registers unchanged.
- Pointer wrap: write ptr 0x0F with data 0x11, 0x22 → reg15=0x11, reg0=0x22; reading from ptr 15 returns 0x11, 0x22.
- Reset mid-byte: assert rst after 4 address bits → sda_o=1 and state IDLE; the following full write frame completes correctly.
- Glitch (macro defined): a 1-clk SCL low pulse during a data-high phase → no extra bit shifted and byte 0xA5 is received intact. Without the macro, the same stimulus corrupts the byte.

Source files
------------

// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C register target.
// State encoding, ACK levels and the bit-counter width.
package i2c_tgt_pkg;

    localparam int BCW = 4;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } tgt_state_e;

endpackage

// File: rtl/i2c_tgt_line_sync.sv
// Two-flop synchronizer plus rise/fall pulses for one bus line.
// I2C_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter.
module i2c_tgt_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       prev;

    // Idle bus level is high, so all history resets to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], d};
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 2'b11;
            filt <= 1'b1;
        end else begin
            hist <= {hist[0], sync[1]};
            filt <= (sync[1] & hist[0]) |
                    (sync[1] & hist[1]) |
                    (hist[0] & hist[1]);
        end
    end

    assign lvl = filt;
`else
    assign lvl = sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b1;
        else     prev <= lvl;
    end

    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a pointer-addressed byte register file.
// Build with I2C_TGT_GLITCH_FILTER_EN to filter SCL/SDA glitches.
module i2c_target_regs
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR = 7'h50,
    parameter int         NREGS    = 16,
    localparam int        PW       = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          scl_o,
    output logic          busy,
    output logic          wr_stb,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic [PW-1:0] rd_idx,
    output logic [7:0]    rd_data
);

    logic scl, scl_r, scl_f;
    logic sda, sda_r, sda_f;
    logic start, stop, rise, fall;
    logic last, full, match, we;
    logic sda_d, busy_d, rw;

    tgt_state_e     state_q, state_d;
    logic [BCW-1:0] cnt;
    logic [7:0]     shift, byte_in, cur;
    logic [PW-1:0]  ptr;
    logic [7:0]     regs [NREGS];

    i2c_tgt_line_sync u_scl (
        .clk(clk), .rst(rst), .d(scl_i),
        .lvl(scl), .rise(scl_r), .fall(scl_f)
    );

    i2c_tgt_line_sync u_sda (
        .clk(clk), .rst(rst), .d(sda_i),
        .lvl(sda), .rise(sda_r), .fall(sda_f)
    );

    // Bus conditions win over a coincident SCL edge.
    assign start   = sda_f & scl;
    assign stop    = sda_r & scl;
    assign rise    = scl_r & ~start & ~stop;
    assign fall    = scl_f & ~start & ~stop;

    assign byte_in = {shift[6:0], sda};
    assign last    = rise && (cnt == BCW'(7));
    assign full    = (cnt == BCW'(8));
    assign match   = (byte_in[7:1] == TGT_ADDR);
    assign we      = last && (state_q == ST_WDATA);
    assign cur     = regs[ptr];
    assign scl_o   = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_ADDR;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (last && !match) state_d = ST_IGNORE;
                    else if (fall && full) state_d = ST_ADDR_ACK;
                end
                ST_ADDR_ACK:
                    if (fall) state_d = rw ? ST_RDATA : ST_PTR;
                ST_PTR:
                    if (fall && full) state_d = ST_PTR_ACK;
                ST_PTR_ACK:
                    if (fall) state_d = ST_WDATA;
                ST_WDATA:
                    if (fall && full) state_d = ST_WDATA_ACK;
                ST_WDATA_ACK:
                    if (fall) state_d = ST_WDATA;
                ST_RDATA:
                    if (fall && full) state_d = ST_RDATA_ACK;
                ST_RDATA_ACK: begin
                    if (rise && sda == I2C_NACK) state_d = ST_IGNORE;
                    else if (fall) state_d = ST_RDATA;
                end
                default: ;
            endcase
        end
    end

    // SDA only moves on an SCL fall, except bus conditions release it.
    always_comb begin
        sda_d  = sda_o;
        busy_d = busy;
        if (stop || start) begin
            sda_d  = 1'b1;
            busy_d = 1'b0;
        end else begin
            if (state_q == ST_ADDR && last && match) busy_d = 1'b1;
            if (fall) begin
                unique case (state_q)
                    ST_ADDR, ST_PTR, ST_WDATA:
                        if (full) sda_d = I2C_ACK;
                    ST_ADDR_ACK:  sda_d = rw ? cur[7] : 1'b1;
                    ST_RDATA:     sda_d = full ? 1'b1 : shift[7];
                    ST_RDATA_ACK: sda_d = cur[7];
                    default:      sda_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            shift   <= '0;
            ptr     <= '0;
            rw      <= 1'b0;
            sda_o   <= 1'b1;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            sda_o  <= sda_d;
            busy   <= busy_d;
            wr_stb <= 1'b0;
            if (start) begin
                cnt <= '0;
            end else if (!stop) begin
                case (state_q)
                    ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA:
                        if (rise && !full) begin
                            shift <= byte_in;
                            cnt   <= cnt + 1'b1;
                        end
                    ST_ADDR_ACK, ST_RDATA_ACK:
                        if (fall) begin
                            cnt   <= '0;
                            shift <= cur;
                        end
                    ST_PTR_ACK, ST_WDATA_ACK:
                        if (fall) cnt <= '0;
                    default: ;
                endcase
                if (last) begin
                    case (state_q)
                        ST_ADDR: rw  <= byte_in[0];
                        ST_PTR:  ptr <= byte_in[PW-1:0];
                        ST_WDATA: begin
                            wr_stb  <= 1'b1;
                            wr_addr <= ptr;
                            wr_data <= byte_in;
                            ptr     <= ptr + 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (state_q == ST_RDATA && fall && full)
                    ptr <= ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[ptr] <= byte_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= regs[rd_idx];
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master plus register model.
module tb_i2c_target_regs;

    localparam int NR = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       scl_i, sda_i;
    logic       sda_o, scl_o, busy, wr_stb;
    logic [3:0] wr_addr, rd_idx;
    logic [7:0] wr_data, rd_data;

    assign scl_i = scl_m & scl_o;
    assign sda_i = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_target_regs #(.TGT_ADDR(7'h50), .NREGS(NR)) dut (
        .clk(clk), .rst(rst),
        .scl_i(scl_i), .sda_i(sda_i),
        .sda_o(sda_o), .scl_o(scl_o),
        .busy(busy), .wr_stb(wr_stb),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  mregs [NR];
    int          mptr;
    logic [7:0]  txq [$];
    logic [11:0] exp_q [$];
    logic [11:0] got [$];
    int          got_rd = 0;
    int          low_cnt = 0;

    always @(negedge clk) begin
        if (wr_stb) got.push_back({wr_addr, wr_data});
        if (sda_o === 1'b0) low_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic m_put(input logic [7:0] b);
        mregs[mptr] = b;
        exp_q.push_back({4'(mptr), b});
        mptr = (mptr + 1) % NR;
    endtask

    task automatic m_get(output logic [7:0] b);
        b = mregs[mptr];
        mptr = (mptr + 1) % NR;
    endtask

    task automatic chk_wr(input string tag);
        check({tag, "_n"}, got.size() - got_rd, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (got_rd + k < got.size())
                check(tag, got[got_rd + k], exp_q[k]);
        got_rd = got.size();
        exp_q.delete();
    endtask

    task automatic check_reg(input int idx);
        rd_idx = 4'(idx);
        tick(3);
        check($sformatf("reg%0d", idx), rd_data, mregs[idx]);
    endtask

    // One SCL clock; SDA set mid-low, sampled mid-high.
    task automatic clk_bit(input logic b, input bit gl, output logic smp);
        tick(4);
        sda_m = b;
        tick(6);
        scl_m = 1'b1;
        tick(4);
        smp = sda_i;
        if (gl) begin
            scl_m = 1'b0;
            tick(1);
            scl_m = 1'b1;
        end
        tick(6);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input int gbit,
                              output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], i == gbit, s);
        clk_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic ackb, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, s);
            b[i] = s;
        end
        clk_bit(ackb, 1'b0, s);
    endtask

    task automatic do_start();
        tick(4);
        sda_m = 1'b1;
        tick(6);
        scl_m = 1'b1;
        tick(6);
        sda_m = 1'b0;
        tick(6);
        scl_m = 1'b0;
    endtask

    task automatic do_stop();
        tick(4);
        sda_m = 1'b0;
        tick(6);
        scl_m = 1'b1;
        tick(6);
        sda_m = 1'b1;
        tick(6);
    endtask

    task automatic wframe(input logic [7:0] p, input string tag);
        logic a;
        do_start();
        write_byte(8'hA0, -1, a);
        check({tag, "_aack"}, a, 1'b0);
        write_byte(p, -1, a);
        check({tag, "_pack"}, a, 1'b0);
        mptr = int'(p) % NR;
        foreach (txq[k]) begin
            write_byte(txq[k], -1, a);
            check($sformatf("%s_dack%0d", tag, k), a, 1'b0);
            m_put(txq[k]);
        end
        check({tag, "_busy"}, busy, 1'b1);
        do_stop();
        check({tag, "_idle"}, busy, 1'b0);
        chk_wr({tag, "_wr"});
        txq.delete();
    endtask

    task automatic rframe(input logic [7:0] p, input int n,
                          input string tag);
        logic a;
        logic [7:0] b, e;
        do_start();
        write_byte(8'hA0, -1, a);
        write_byte(p, -1, a);
        mptr = int'(p) % NR;
        do_start();
        write_byte(8'hA1, -1, a);
        check({tag, "_rack"}, a, 1'b0);
        for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, b);
            m_get(e);
            check($sformatf("%s_rd%0d", tag, k), b, e);
        end
        check({tag, "_busy"}, busy, 1'b1);
        do_stop();
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic a, s;
        int lo0, n;
        logic [7:0] p, gb;

        rst = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        rd_idx = '0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        mptr = 0;
        tick(4);
        rst = 1'b0;
        tick(3);
        check("rst_sda", sda_o, 1'b1);
        check("rst_scl", scl_o, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_stb", wr_stb, 1'b0);
        check("rst_waddr", wr_addr, 4'h0);
        check("rst_wdata", wr_data, 8'h00);
        check("rst_rdata", rd_data, 8'h00);

        txq = '{8'hA5, 8'h3C};
        wframe(8'h02, "w1");
        check_reg(3);
        check_reg(2);

        rframe(8'h02, 2, "r1");

        lo0 = low_cnt;
        do_start();
        write_byte(8'hA2, -1, a);
        check("mm_aack", a, 1'b1);
        write_byte(8'h00, -1, a);
        check("mm_b1", a, 1'b1);
        write_byte(8'hFF, -1, a);
        check("mm_b2", a, 1'b1);
        check("mm_busy", busy, 1'b0);
        do_stop();
        check("mm_low", low_cnt - lo0, 0);
        chk_wr("mm_wr");
        check_reg(0);

        txq = '{8'h11, 8'h22};
        wframe(8'h0F, "wrap");
        check_reg(15);
        check_reg(0);
        rframe(8'h0F, 2, "wrapr");

        for (int r = 0; r < 6; r++) begin
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
            wframe(p, $sformatf("rw%0d", r));
            rframe(p, n, $sformatf("rr%0d", r));
        end
        for (int i = 0; i < NR; i++) check_reg(i);

        do_start();
        for (int i = 7; i >= 4; i--) clk_bit(p[i] | 1'b1 & (i == 7 || i == 5), 1'b0, s);
        tick(2);
        rst = 1'b1;
        tick(3);
        check("mid_sda", sda_o, 1'b1);
        check("mid_busy", busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        mptr = 0;
        lo0 = low_cnt;
        for (int i = 3; i >= 0; i--) clk_bit(1'b0, 1'b0, s);
        clk_bit(1'b1, 1'b0, s);
        do_stop();
        check("mid_low", low_cnt - lo0, 0);
        chk_wr("mid_wr");
        check_reg(9);
        txq = '{8'h77, 8'h88};
        wframe(8'h05, "post");
        check_reg(5);
        check_reg(6);

        // Glitch on the high phase of data bit 7 of 0xA5.
        gb = 8'hA5;
        do_start();
        write_byte(8'hA0, -1, a);
        write_byte(8'h02, -1, a);
        mptr = 2;
        write_byte(gb, 7, a);
        do_stop();
`ifdef I2C_TGT_GLITCH_FILTER_EN
        m_put(gb);
`else
        m_put({gb[7], gb[7:1]});
`endif
        chk_wr("glitch_wr");
        check_reg(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
